// File: rtl/except_ctrl_if.sv
// MEM-stage / CP0 bundle seen by the exception arbiter.
// slave = except_ctrl side, master = pipeline/CP0 side.
interface except_ctrl_if;
   logic        mem_valid_i;
   logic [31:0] mem_pc_i;
   logic        mem_in_ds_i;
   logic [31:0] mem_vaddr_i;
   logic [8:0]  mem_exc_i;
   logic [31:0] cp0_status_i;
   logic [31:0] cp0_cause_i;
   logic [31:0] cp0_epc_i;
   logic        cp0_we_i;
   logic [4:0]  cp0_waddr_i;
   logic [31:0] cp0_wdata_i;
   logic [31:0] excepttype_o;
   logic [31:0] exc_pc_o;
   logic [31:0] bad_vaddr_o;
   logic        in_ds_o;
   logic        flush_o;
   logic [31:0] new_pc_o;

   modport slave (
      input  mem_valid_i, mem_pc_i, mem_in_ds_i, mem_vaddr_i, mem_exc_i,
      input  cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_we_i, cp0_waddr_i, cp0_wdata_i,
      output excepttype_o, exc_pc_o, bad_vaddr_o, in_ds_o, flush_o, new_pc_o
   );

   modport master (
      output mem_valid_i, mem_pc_i, mem_in_ds_i, mem_vaddr_i, mem_exc_i,
      output cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_we_i, cp0_waddr_i, cp0_wdata_i,
      input  excepttype_o, exc_pc_o, bad_vaddr_o, in_ds_o, flush_o, new_pc_o
   );
endinterface

// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: picks the highest-priority event for CP0 and
// issues a fixed-length pipeline flush with the redirect PC.
module except_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [5:0]   hw_int_i,
   output logic [5:0]   sync_int_o,
   except_ctrl_if.slave bus
);
   localparam int unsigned     CNT_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [4:0]      ADDR_STATUS = 5'd12;
   localparam logic [4:0]      ADDR_CAUSE  = 5'd13;
   localparam logic [4:0]      ADDR_EPC    = 5'd14;

   typedef enum logic {S_IDLE, S_FLUSH} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              flush_q, flush_d;
   logic [31:0]       new_pc_q, new_pc_d;
   logic [5:0]        sync_q [SYNC_STAGES];
   logic [5:0]        sync_d [SYNC_STAGES];

   logic [31:0] eff_status, eff_epc;
   logic [7:0]  eff_ip;
   logic        int_pend_c, is_eret_c, event_c;
   logic [7:0]  code_c;
   logic [31:0] bva_c;
   logic        unused_c;

   // interrupt pin synchronizer
   always_comb begin
      sync_d[0] = hw_int_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
   end
   assign sync_int_o = sync_q[SYNC_STAGES-1];

   // same-cycle CP0 writes override the register values
   always_comb begin
      eff_status = bus.cp0_status_i;
      eff_epc    = bus.cp0_epc_i;
      eff_ip     = bus.cp0_cause_i[15:8];
      if (bus.cp0_we_i && bus.cp0_waddr_i == ADDR_STATUS) eff_status  = bus.cp0_wdata_i;
      if (bus.cp0_we_i && bus.cp0_waddr_i == ADDR_CAUSE)  eff_ip[1:0] = bus.cp0_wdata_i[9:8];
      if (bus.cp0_we_i && bus.cp0_waddr_i == ADDR_EPC)    eff_epc     = bus.cp0_wdata_i;
   end

   assign int_pend_c = (|(eff_ip & eff_status[15:8])) & eff_status[0] & ~eff_status[1];

   // fixed-priority event select; mem_exc_i bit order already matches priority
   always_comb begin
      code_c    = 8'h00;
      bva_c     = 32'h0;
      is_eret_c = 1'b0;
      if (int_pend_c)            code_c = 8'h01;
      else if (bus.mem_exc_i[0]) begin code_c = 8'h04; bva_c = bus.mem_pc_i; end
      else if (bus.mem_exc_i[1]) code_c = 8'h0a;
      else if (bus.mem_exc_i[2]) code_c = 8'h0c;
      else if (bus.mem_exc_i[3]) code_c = 8'h0d;
      else if (bus.mem_exc_i[4]) code_c = 8'h08;
      else if (bus.mem_exc_i[5]) code_c = 8'h09;
      else if (bus.mem_exc_i[6]) begin code_c = 8'h04; bva_c = bus.mem_vaddr_i; end
      else if (bus.mem_exc_i[7]) begin code_c = 8'h05; bva_c = bus.mem_vaddr_i; end
      else if (bus.mem_exc_i[8]) begin code_c = 8'h0e; is_eret_c = 1'b1; end
   end

   assign event_c = bus.mem_valid_i && (state_q == S_IDLE) && (code_c != 8'h00);

   assign bus.excepttype_o = event_c ? {24'h0, code_c} : 32'h0;
   assign bus.bad_vaddr_o  = event_c ? bva_c : 32'h0;
   assign bus.exc_pc_o     = bus.mem_pc_i;
   assign bus.in_ds_o      = bus.mem_in_ds_i;
   assign bus.flush_o      = flush_q;
   assign bus.new_pc_o     = new_pc_q;

   // flush sequencer
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      new_pc_d = new_pc_q;
      case (state_q)
         S_IDLE: begin
            if (event_c) begin
               state_d  = S_FLUSH;
               cnt_d    = CNT_INIT;
               new_pc_d = is_eret_c ? eff_epc : EXC_VECTOR;
            end
         end
         S_FLUSH: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
      flush_d = (state_d == S_FLUSH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         flush_q  <= 1'b0;
         new_pc_q <= 32'h0;
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 6'h0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         flush_q  <= flush_d;
         new_pc_q <= new_pc_d;
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      end
   end

   assign unused_c = ^{bus.cp0_cause_i[31:16], bus.cp0_cause_i[7:0],
                       eff_status[31:16], eff_status[7:2]};
endmodule

// File: tb/tb_except_ctrl.sv
// Directed and randomized checks of except_ctrl against a rule-level model.
module tb_except_ctrl;
   localparam logic [31:0] EXC_VECTOR   = 32'hBFC00380;
   localparam int          FLUSH_CYCLES = 2;
   localparam int          SYNC_STAGES  = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] hw_int, sync_int;

   except_ctrl_if bus();

   except_ctrl #(
      .EXC_VECTOR(EXC_VECTOR), .FLUSH_CYCLES(FLUSH_CYCLES), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .rst(rst), .hw_int_i(hw_int), .sync_int_o(sync_int), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // model state: flush cycles still owed, redirect PC, history of pin values
   int          fl;
   logic [31:0] npc_m, npc_next;
   logic        acc_m;
   logic [5:0]  sq[$];

   // cause codes by mem_exc_i bit: adel_if ri ov trap sys brk adel_ld ades eret
   int exc_codes [9] = '{'h04, 'h0a, 'h0c, 'h0d, 'h08, 'h09, 'h04, 'h05, 'h0e};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      fl = 0; npc_m = 32'h0; acc_m = 1'b0; npc_next = EXC_VECTOR;
      sq.delete();
   endtask

   task automatic clear_in();
      bus.mem_valid_i = 1'b0; bus.mem_pc_i = 32'h0; bus.mem_in_ds_i = 1'b0;
      bus.mem_vaddr_i = 32'h0; bus.mem_exc_i = 9'h0;
      bus.cp0_status_i = 32'h0; bus.cp0_cause_i = 32'h0; bus.cp0_epc_i = 32'h0;
      bus.cp0_we_i = 1'b0; bus.cp0_waddr_i = 5'h0; bus.cp0_wdata_i = 32'h0;
   endtask

   // mid-cycle: compute the expected event from the rules and compare comb outputs
   task automatic eval();
      logic [31:0] st, epc, code, bva;
      logic [7:0]  ip;
      logic        pend;
      #3;
      st  = (bus.cp0_we_i && bus.cp0_waddr_i == 5'd12) ? bus.cp0_wdata_i : bus.cp0_status_i;
      epc = (bus.cp0_we_i && bus.cp0_waddr_i == 5'd14) ? bus.cp0_wdata_i : bus.cp0_epc_i;
      ip  = {bus.cp0_cause_i[15:10],
             (bus.cp0_we_i && bus.cp0_waddr_i == 5'd13) ? bus.cp0_wdata_i[9:8] : bus.cp0_cause_i[9:8]};
      pend = ((ip & st[15:8]) != 8'h0) && st[0] && !st[1];
      code = 32'h0; bva = 32'h0; npc_next = EXC_VECTOR;
      if (fl == 0 && bus.mem_valid_i) begin
         if (pend) code = 32'h1;
         else begin
            for (int i = 0; i < 9; i++) begin
               if (code == 32'h0 && bus.mem_exc_i[i]) begin
                  code = 32'(exc_codes[i]);
                  if (i == 0)           bva = bus.mem_pc_i;
                  if (i == 6 || i == 7) bva = bus.mem_vaddr_i;
                  if (i == 8)           npc_next = epc;
               end
            end
         end
      end
      acc_m = (code != 32'h0);
      chk("excepttype", bus.excepttype_o, code);
      chk("bad_vaddr", bus.bad_vaddr_o, bva);
      chk("exc_pc", bus.exc_pc_o, bus.mem_pc_i);
      chk("in_ds", 32'(bus.in_ds_o), 32'(bus.mem_in_ds_i));
   endtask

   // clock edge: advance the model and compare registered outputs
   task automatic tick();
      @(posedge clk);
      if (acc_m) begin fl = FLUSH_CYCLES; npc_m = npc_next; end
      else if (fl > 0) fl--;
      sq.push_back(hw_int);
      if (sq.size() > SYNC_STAGES) void'(sq.pop_front());
      #1;
      chk("flush", 32'(bus.flush_o), 32'(fl > 0));
      chk("new_pc", bus.new_pc_o, npc_m);
      chk("sync_int", 32'(sync_int), (sq.size() == SYNC_STAGES) ? 32'(sq[0]) : 32'h0);
   endtask

   task automatic drain();
      bus.mem_valid_i = 1'b0;
      repeat (FLUSH_CYCLES) begin eval(); tick(); end
   endtask

   initial begin
      rst = 1'b0; hw_int = 6'h0;
      clear_in(); model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      eval(); tick();

      // syscall
      bus.mem_valid_i = 1'b1; bus.mem_pc_i = 32'hBFC00100; bus.mem_exc_i = 9'h010;
      bus.cp0_status_i = 32'h1;
      eval(); chk("sys_code", bus.excepttype_o, 32'h08);
      tick(); chk("sys_flush1", 32'(bus.flush_o), 32'h1);
      chk("sys_newpc", bus.new_pc_o, 32'hBFC00380);
      bus.mem_valid_i = 1'b0;
      eval(); tick(); chk("sys_flush2", 32'(bus.flush_o), 32'h1);
      eval(); tick(); chk("sys_flush_end", 32'(bus.flush_o), 32'h0);

      // async reset in the middle of a flush
      bus.mem_valid_i = 1'b1;
      eval(); tick();
      #2 rst = 1'b0;
      #1 chk("rst_flush", 32'(bus.flush_o), 32'h0);
      chk("rst_newpc", bus.new_pc_o, 32'h0);
      model_reset();
      bus.mem_valid_i = 1'b0;
      #1 rst = 1'b1;
      eval(); chk("rst_code", bus.excepttype_o, 32'h0);
      tick();

      // priority: ov beats ades and eret
      bus.mem_valid_i = 1'b1; bus.mem_exc_i = 9'h184; bus.mem_vaddr_i = 32'h1003;
      eval(); chk("prio_code", bus.excepttype_o, 32'h0c);
      chk("prio_bva", bus.bad_vaddr_o, 32'h0);
      tick(); drain();
      bus.mem_valid_i = 1'b1; bus.mem_exc_i = 9'h080;
      eval(); chk("ades_code", bus.excepttype_o, 32'h05);
      chk("ades_bva", bus.bad_vaddr_o, 32'h1003);
      tick(); drain();

      // interrupt
      bus.mem_exc_i = 9'h0; bus.cp0_status_i = 32'h0000_0401; hw_int = 6'h01;
      eval(); tick(); eval(); tick();
      chk("sync0", 32'(sync_int[0]), 32'h1);
      bus.cp0_cause_i = 32'h400; bus.mem_valid_i = 1'b1; bus.mem_exc_i = 9'h010;
      eval(); chk("int_code", bus.excepttype_o, 32'h01);
      tick(); drain();
      bus.cp0_status_i = 32'h0000_0403; bus.mem_valid_i = 1'b1;
      eval(); chk("exl_code", bus.excepttype_o, 32'h08);
      tick(); drain();
      hw_int = 6'h0; bus.cp0_cause_i = 32'h0; bus.cp0_status_i = 32'h1;

      // eret with forwarded EPC
      bus.cp0_epc_i = 32'h100; bus.cp0_we_i = 1'b1; bus.cp0_waddr_i = 5'd14;
      bus.cp0_wdata_i = 32'hBFC00200; bus.mem_exc_i = 9'h100; bus.mem_valid_i = 1'b1;
      eval(); chk("eret_code", bus.excepttype_o, 32'h0e);
      tick(); chk("eret_newpc", bus.new_pc_o, 32'hBFC00200);
      bus.cp0_we_i = 1'b0;
      drain();

      // blanking during flush, then back-to-back acceptance
      bus.mem_exc_i = 9'h010; bus.mem_valid_i = 1'b1;
      eval(); tick();
      eval(); chk("blank1", bus.excepttype_o, 32'h0); tick();
      eval(); chk("blank2", bus.excepttype_o, 32'h0); tick();
      eval(); chk("after_blank", bus.excepttype_o, 32'h08); tick();
      drain();

      // randomized traffic
      repeat (400) begin
         bus.mem_valid_i  = ($urandom_range(0, 3) != 0);
         bus.mem_pc_i     = $urandom;
         bus.mem_in_ds_i  = 1'($urandom);
         bus.mem_vaddr_i  = $urandom;
         bus.mem_exc_i    = 9'($urandom) & 9'($urandom) & 9'($urandom);
         bus.cp0_status_i = $urandom;
         bus.cp0_status_i[15:8] = 8'($urandom) & 8'($urandom) & 8'($urandom);
         bus.cp0_status_i[1]    = ($urandom_range(0, 3) == 0);
         bus.cp0_status_i[0]    = ($urandom_range(0, 3) != 0);
         bus.cp0_cause_i  = $urandom;
         bus.cp0_epc_i    = $urandom;
         bus.cp0_we_i     = 1'($urandom);
         bus.cp0_waddr_i  = 5'(12 + $urandom_range(0, 3));
         bus.cp0_wdata_i  = $urandom;
         hw_int           = 6'($urandom);
         eval(); tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
